// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the multi-accumulator ALU and its control unit.
package alu_pkg;

    localparam logic [3:0] ALU_RESET  = 4'h0;
    localparam logic [3:0] ALU_ADD    = 4'h1;
    localparam logic [3:0] ALU_SUB    = 4'h2;
    localparam logic [3:0] ALU_AND    = 4'h3;
    localparam logic [3:0] ALU_OR     = 4'h4;
    localparam logic [3:0] ALU_XOR    = 4'h5;
    localparam logic [3:0] ALU_LSHIFT = 4'h6;
    localparam logic [3:0] ALU_RSHIFT = 4'h7;
    localparam logic [3:0] ALU_REGA   = 4'h8;
    localparam logic [3:0] ALU_OUT    = 4'h9;
    localparam logic [3:0] ALU_NOOP   = 4'hF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_LSHIFT) || (op == ALU_RSHIFT);
    endfunction

endpackage

// File: rtl/alu_shift_ctrl.sv
// Shift sequencer: holds the latched channel/direction, counts down one bit per cycle,
// and owns op_ready (low while a shift is in flight).
module alu_shift_ctrl
    import alu_pkg::*;
#(
    parameter int ACC_SEL_W = 2,
    parameter int SHAMT_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 start_dir,
    input  logic [ACC_SEL_W-1:0] start_ch,
    input  logic [SHAMT_W-1:0]   start_cnt,
    output logic                 op_ready,
    output logic                 shift_step,
    output logic                 shift_dir,
    output logic [ACC_SEL_W-1:0] shift_ch
);

    alu_state_e         state, state_nxt;
    logic [SHAMT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            shift_dir <= 1'b0;
            shift_ch  <= '0;
        end else if (start) begin
            cnt       <= start_cnt;
            shift_dir <= start_dir;
            shift_ch  <= start_ch;
        end else if (shift_step) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == SHAMT_W'(1)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        op_ready   = (state == ST_IDLE);
        shift_step = (state == ST_SHIFT);
    end

endmodule

// File: rtl/alu_multi_acc.sv
// Multi-accumulator ALU with valid/ready op handshake and bit-serial shifts.
// Optional ALU_SAT_EN: saturating ADD/SUB instead of modulo arithmetic.
module alu_multi_acc
    import alu_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_ACC    = 4,
    localparam int ACC_SEL_W  = $clog2(NUM_ACC),
    localparam int SHAMT_W    = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [3:0]            opcode,
    input  logic [ACC_SEL_W-1:0]  acc_sel,
    input  logic                  op_valid,
    output logic                  op_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic                  acc_overflow,
    output logic                  acc_zero,
    output logic                  acc_negative
);

    logic [NUM_ACC-1:0][DATA_WIDTH:0] acc, acc_nxt;
    logic [DATA_WIDTH-1:0] reg_a;
    logic [DATA_WIDTH:0]   acc_cur, reg_a_ext, op_res, sh_src, sh_res;
    logic [SHAMT_W-1:0]    shamt_raw, shamt;
    logic                  accept, op_wr, sh_start;
    logic                  shift_step, shift_dir;
    logic [ACC_SEL_W-1:0]  shift_ch;

    assign accept    = op_valid && op_ready;
    assign acc_cur   = acc[acc_sel];
    assign reg_a_ext = {1'b0, reg_a};

    assign shamt_raw = data_in[SHAMT_W-1:0];
    assign shamt     = (shamt_raw > SHAMT_W'(DATA_WIDTH)) ? SHAMT_W'(DATA_WIDTH) : shamt_raw;
    assign sh_start  = accept && is_shift_op(opcode) && (shamt != '0);

    alu_shift_ctrl #(
        .ACC_SEL_W (ACC_SEL_W),
        .SHAMT_W   (SHAMT_W)
    ) u_shift_ctrl (
        .clk        (clk),
        .reset      (reset),
        .start      (sh_start),
        .start_dir  (opcode == ALU_RSHIFT),
        .start_ch   (acc_sel),
        .start_cnt  (shamt),
        .op_ready   (op_ready),
        .shift_step (shift_step),
        .shift_dir  (shift_dir),
        .shift_ch   (shift_ch)
    );

    // Right shifts drop the carry on every step; after the first it is already zero.
    assign sh_src = acc[shift_ch];
    assign sh_res = shift_dir ? {2'b00, sh_src[DATA_WIDTH-1:1]} : {sh_src[DATA_WIDTH-1:0], 1'b0};

`ifdef ALU_SAT_EN
    logic [DATA_WIDTH:0] sat_sum, sat_diff;
    assign sat_sum  = {1'b0, acc_cur[DATA_WIDTH-1:0]} + reg_a_ext;
    assign sat_diff = {1'b0, acc_cur[DATA_WIDTH-1:0]} - reg_a_ext;
`endif

    always_comb begin
        op_res = acc_cur;
        op_wr  = 1'b0;
        case (opcode)
            ALU_RESET: begin op_res = '0;                   op_wr = accept; end
`ifdef ALU_SAT_EN
            ALU_ADD: begin
                op_res = sat_sum[DATA_WIDTH] ? {1'b1, {DATA_WIDTH{1'b1}}}
                                             : {acc_cur[DATA_WIDTH], sat_sum[DATA_WIDTH-1:0]};
                op_wr  = accept;
            end
            ALU_SUB: begin
                op_res = sat_diff[DATA_WIDTH] ? {1'b1, {DATA_WIDTH{1'b0}}}
                                              : {acc_cur[DATA_WIDTH], sat_diff[DATA_WIDTH-1:0]};
                op_wr  = accept;
            end
`else
            ALU_ADD:   begin op_res = acc_cur + reg_a_ext;  op_wr = accept; end
            ALU_SUB:   begin op_res = acc_cur - reg_a_ext;  op_wr = accept; end
`endif
            ALU_AND:   begin op_res = acc_cur & reg_a_ext;  op_wr = accept; end
            ALU_OR:    begin op_res = acc_cur | reg_a_ext;  op_wr = accept; end
            ALU_XOR:   begin op_res = acc_cur ^ reg_a_ext;  op_wr = accept; end
            default:   begin op_res = acc_cur;              op_wr = 1'b0;   end
        endcase
    end

    // Step and single-cycle write never coincide: ops are only accepted in IDLE.
    for (genvar i = 0; i < NUM_ACC; i++) begin : g_acc
        assign acc_nxt[i] = (shift_step && shift_ch == ACC_SEL_W'(i)) ? sh_res :
                            (op_wr && acc_sel == ACC_SEL_W'(i))       ? op_res : acc[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            reg_a     <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            acc       <= acc_nxt;
            out_valid <= accept && (opcode == ALU_OUT);
            if (accept && opcode == ALU_REGA) reg_a    <= data_in;
            if (accept && opcode == ALU_OUT)  data_out <= acc_cur[DATA_WIDTH-1:0];
        end
    end

    assign acc_overflow = acc_cur[DATA_WIDTH];
    assign acc_zero     = (acc_cur == '0);
    assign acc_negative = acc_cur[DATA_WIDTH-1];

endmodule
